msrv32_branch_predict_unit: RTL and testbench

Parametrised successor to msrv32_branch_unit. It resolves conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) with one registered cycle of latency. It holds a PC-indexed branch history table (BHT) of 2-bit saturating counters, gives a taken/not-taken prediction to fetch, and flags mispredicts for the pipeline flush logic. It sits between decode/register-read and the PC mux.

---
 rtl/msrv32_pkg.sv | 32 +++
 rtl/msrv32_branch_cmp.sv | 31 +++
 rtl/msrv32_branch_predict_unit.sv | 117 +++++++++++
 tb/tb_msrv32_branch_predict_unit.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_pkg.sv
// Shared constants and types for the msrv32 branch resolve/predict logic.
package msrv32_pkg;

  localparam logic [4:0] OPCODE_BRANCH = 5'b11000;

  localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BLT  = 3'b100;
  localparam logic [2:0] FUNCT3_BGE  = 3'b101;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;

  typedef logic [1:0] bht_ctr_t;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_e;

  // Two-bit saturating counter step toward the resolved outcome.
  function automatic bht_ctr_t ctr_next(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t nxt;
    nxt = ctr;
    if (taken && ctr != 2'b11) begin
      nxt = ctr + 2'b01;
    end else if (!taken && ctr != 2'b00) begin
      nxt = ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/msrv32_branch_cmp.sv
// Combinational conditional-branch evaluator: decodes the branch opcode and funct3.
module msrv32_branch_cmp
  import msrv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [4:0]      opcode,
  input  logic [2:0]      funct3,
  output logic            is_branch,
  output logic            taken
);

  always_comb begin
    is_branch = (opcode == OPCODE_BRANCH);
    taken     = 1'b0;
    if (is_branch) begin
      case (funct3)
        FUNCT3_BEQ:  taken = (rs1 == rs2);
        FUNCT3_BNE:  taken = (rs1 != rs2);
        FUNCT3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
        FUNCT3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
        FUNCT3_BLTU: taken = (rs1 <  rs2);
        FUNCT3_BGEU: taken = (rs1 >= rs2);
        default:     taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/msrv32_branch_predict_unit.sv
// Branch resolve unit with a PC-indexed 2-bit BHT predictor and mispredict flag.
// Optional performance counters are built when MSRV32_BP_PERF_CNT_EN is defined.
module msrv32_branch_predict_unit
  import msrv32_pkg::*;
#(
  parameter int       XLEN      = 32,
  parameter int       BHT_DEPTH = 64,
  parameter bht_ctr_t BHT_INIT  = 2'b01
) (
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            ms_riscv32_mp_rst_in,
  input  logic [XLEN-1:0] predict_pc_in,
  output logic            predict_taken_out,
  input  logic            resolve_valid_in,
  input  logic [XLEN-1:0] resolve_pc_in,
  input  logic [XLEN-1:0] rs1_in,
  input  logic [XLEN-1:0] rs2_in,
  input  logic [4:0]      opcode_in,
  input  logic [2:0]      funct3_in,
  input  logic            predicted_taken_in,
  output logic            resolve_valid_out,
  output logic            branch_taken_out,
  output logic            mispredict_out,
  output logic            busy_out,
`ifdef MSRV32_BP_PERF_CNT_EN
  output logic [31:0]     branch_count_out,
  output logic [31:0]     mispredict_count_out,
`endif
  output bp_state_e       state_out
);

  localparam int IDXW = $clog2(BHT_DEPTH);

  // Handshake: resolve_valid_in qualifies a request every cycle with no backpressure;
  // resolve_valid_out is its one-cycle registered echo and qualifies the other outputs.

  bht_ctr_t        bht [BHT_DEPTH];
  bp_state_e       state;
  logic [IDXW-1:0] init_idx;
  logic [IDXW-1:0] predict_idx;
  logic [IDXW-1:0] resolve_idx;
  logic            is_branch;
  logic            cond_taken;
  logic            unused_pc_bits;

  assign predict_idx = predict_pc_in[IDXW+1:2];
  assign resolve_idx = resolve_pc_in[IDXW+1:2];
  assign unused_pc_bits = ^{predict_pc_in[XLEN-1:IDXW+2], predict_pc_in[1:0],
                            resolve_pc_in[XLEN-1:IDXW+2], resolve_pc_in[1:0]};

  msrv32_branch_cmp #(
    .XLEN (XLEN)
  ) u_cmp (
    .rs1       (rs1_in),
    .rs2       (rs2_in),
    .opcode    (opcode_in),
    .funct3    (funct3_in),
    .is_branch (is_branch),
    .taken     (cond_taken)
  );

  assign busy_out          = (state == INIT);
  assign state_out         = state;
  assign predict_taken_out = (state == RUN) && bht[predict_idx][1];

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state    <= INIT;
      init_idx <= '0;
    end else if (state == INIT) begin
      init_idx <= init_idx + 1'b1;
      if (init_idx == IDXW'(BHT_DEPTH - 1)) begin
        state <= RUN;
      end
    end
  end

  // Table is not reset; the INIT sweep owns it until RUN, then resolves train it.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      if (state == INIT) begin
        bht[init_idx] <= BHT_INIT;
      end else if (resolve_valid_in && is_branch) begin
        bht[resolve_idx] <= ctr_next(bht[resolve_idx], cond_taken);
      end
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      resolve_valid_out <= 1'b0;
      branch_taken_out  <= 1'b0;
      mispredict_out    <= 1'b0;
    end else begin
      resolve_valid_out <= resolve_valid_in;
      branch_taken_out  <= resolve_valid_in && cond_taken;
      mispredict_out    <= resolve_valid_in && is_branch && (cond_taken != predicted_taken_in);
    end
  end

`ifdef MSRV32_BP_PERF_CNT_EN
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      branch_count_out     <= '0;
      mispredict_count_out <= '0;
    end else if (resolve_valid_in && is_branch) begin
      if (branch_count_out != 32'hFFFF_FFFF) begin
        branch_count_out <= branch_count_out + 32'd1;
      end
      if ((cond_taken != predicted_taken_in) && mispredict_count_out != 32'hFFFF_FFFF) begin
        mispredict_count_out <= mispredict_count_out + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_msrv32_branch_predict_unit.sv
// Directed self-checking bench for msrv32_branch_predict_unit (default parameters).
module tb_msrv32_branch_predict_unit;
  import msrv32_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] predict_pc_in;
  logic        predict_taken_out;
  logic        resolve_valid_in;
  logic [31:0] resolve_pc_in;
  logic [31:0] rs1_in;
  logic [31:0] rs2_in;
  logic [4:0]  opcode_in;
  logic [2:0]  funct3_in;
  logic        predicted_taken_in;
  logic        resolve_valid_out;
  logic        branch_taken_out;
  logic        mispredict_out;
  logic        busy_out;
  bp_state_e   state_out;
`ifdef MSRV32_BP_PERF_CNT_EN
  logic [31:0] branch_count_out;
  logic [31:0] mispredict_count_out;
`endif

  int checks = 0;
  int errors = 0;

  msrv32_branch_predict_unit dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .predict_pc_in        (predict_pc_in),
    .predict_taken_out    (predict_taken_out),
    .resolve_valid_in     (resolve_valid_in),
    .resolve_pc_in        (resolve_pc_in),
    .rs1_in               (rs1_in),
    .rs2_in               (rs2_in),
    .opcode_in            (opcode_in),
    .funct3_in            (funct3_in),
    .predicted_taken_in   (predicted_taken_in),
    .resolve_valid_out    (resolve_valid_out),
    .branch_taken_out     (branch_taken_out),
    .mispredict_out       (mispredict_out),
    .busy_out             (busy_out),
`ifdef MSRV32_BP_PERF_CNT_EN
    .branch_count_out     (branch_count_out),
    .mispredict_count_out (mispredict_count_out),
`endif
    .state_out            (state_out)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: present one resolve request, clock it in, then drop valid.
  task automatic drive_resolve(input logic [31:0] pc, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] op,
                               input logic [2:0] f3, input logic pred);
    resolve_pc_in      = pc;
    rs1_in             = a;
    rs2_in             = b;
    opcode_in          = op;
    funct3_in          = f3;
    predicted_taken_in = pred;
    resolve_valid_in   = 1'b1;
    @(posedge clk); #1;
    resolve_valid_in   = 1'b0;
  endtask

  task automatic read_predict(input logic [31:0] pc, output logic p);
    predict_pc_in = pc;
    #1;
    p = predict_taken_out;
  endtask

  task automatic test_reset();
    int   busy_cycles;
    int   pred_bad;
    bit   done;
    logic p;
    busy_cycles = 0;
    pred_bad    = 0;
    done        = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({resolve_valid_out, branch_taken_out, mispredict_out} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000",
               {resolve_valid_out, branch_taken_out, mispredict_out});
    end
    checks++;
    if (busy_out !== 1'b1 || state_out !== INIT) begin
      errors++;
      $display("FAIL reset_state: got busy=%b state=%0d expected busy=1 state=0", busy_out, state_out);
    end
    rst = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      predict_pc_in = 32'(c) << 2;
      @(negedge clk);
      if (busy_out === 1'b1) begin
        busy_cycles++;
        if (predict_taken_out !== 1'b0) pred_bad++;
      end else begin
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (busy_cycles != 64) begin
      errors++;
      $display("FAIL init_length: got %0d cycles expected 64", busy_cycles);
    end
    checks++;
    if (pred_bad != 0) begin
      errors++;
      $display("FAIL predict_during_init: got %0d taken predictions expected 0", pred_bad);
    end
    read_predict(32'h0000_0040, p);
    checks++;
    if (p !== 1'b0) begin
      errors++;
      $display("FAIL predict_after_init: got %b expected 0", p);
    end
  endtask

  task automatic test_beq_mispredict();
    logic p;
    drive_resolve(32'h40, 32'd10, 32'd10, OPCODE_BRANCH, FUNCT3_BEQ, 1'b0);
    checks++;
    if ({resolve_valid_out, branch_taken_out, mispredict_out} !== 3'b111) begin
      errors++;
      $display("FAIL beq_resolve: got %b expected 111",
               {resolve_valid_out, branch_taken_out, mispredict_out});
    end
    read_predict(32'h40, p);
    checks++;
    if (p !== 1'b1) begin
      errors++;
      $display("FAIL beq_train: got %b expected 1", p);
    end
    @(posedge clk); #1;
    checks++;
    if ({resolve_valid_out, branch_taken_out, mispredict_out} !== 3'b000) begin
      errors++;
      $display("FAIL idle_outputs: got %b expected 000",
               {resolve_valid_out, branch_taken_out, mispredict_out});
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic        pred;
    logic        exp_taken;
    logic        exp_misp;
  } cond_vec_t;

  task automatic test_conditions();
    cond_vec_t v [10];
    v[0] = '{32'hFFFF_FFFF, 32'd1,         FUNCT3_BLT,  1'b0, 1'b1, 1'b1};
    v[1] = '{32'hFFFF_FFFF, 32'd1,         FUNCT3_BLTU, 1'b0, 1'b0, 1'b0};
    v[2] = '{32'd5,         32'd5,         FUNCT3_BGE,  1'b1, 1'b1, 1'b0};
    v[3] = '{32'd5,         32'd5,         FUNCT3_BGEU, 1'b0, 1'b1, 1'b1};
    v[4] = '{32'd3,         32'd4,         FUNCT3_BNE,  1'b1, 1'b1, 1'b0};
    v[5] = '{32'd3,         32'd4,         FUNCT3_BEQ,  1'b1, 1'b0, 1'b1};
    v[6] = '{32'd5,         32'd5,         3'b010,      1'b1, 1'b0, 1'b1};
    v[7] = '{32'd5,         32'd5,         FUNCT3_BLT,  1'b0, 1'b0, 1'b0};
    v[8] = '{32'd1,         32'hFFFF_FFFF, FUNCT3_BLTU, 1'b0, 1'b1, 1'b1};
    v[9] = '{32'd1,         32'hFFFF_FFFF, FUNCT3_BGE,  1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive_resolve(32'h3A0 + 32'(i * 4), v[i].a, v[i].b, OPCODE_BRANCH, v[i].f3, v[i].pred);
      checks++;
      if ({resolve_valid_out, branch_taken_out, mispredict_out} !== {1'b1, v[i].exp_taken, v[i].exp_misp}) begin
        errors++;
        $display("FAIL cond_vec%0d: got %b expected %b", i,
                 {resolve_valid_out, branch_taken_out, mispredict_out},
                 {1'b1, v[i].exp_taken, v[i].exp_misp});
      end
    end
  endtask

  task automatic test_saturate();
    logic p;
    for (int i = 0; i < 4; i++) begin
      drive_resolve(32'h100, 32'd7, 32'd7, OPCODE_BRANCH, FUNCT3_BEQ, 1'b1);
    end
    checks++;
    if ({branch_taken_out, mispredict_out} !== 2'b10) begin
      errors++;
      $display("FAIL sat_taken: got %b expected 10", {branch_taken_out, mispredict_out});
    end
    drive_resolve(32'h100, 32'd7, 32'd8, OPCODE_BRANCH, FUNCT3_BEQ, 1'b1);
    checks++;
    if ({branch_taken_out, mispredict_out} !== 2'b01) begin
      errors++;
      $display("FAIL sat_not_taken: got %b expected 01", {branch_taken_out, mispredict_out});
    end
    read_predict(32'h100, p);
    checks++;
    if (p !== 1'b1) begin
      errors++;
      $display("FAIL sat_after_one_dec: got %b expected 1", p);
    end
    drive_resolve(32'h100, 32'd7, 32'd8, OPCODE_BRANCH, FUNCT3_BEQ, 1'b1);
    read_predict(32'h100, p);
    checks++;
    if (p !== 1'b0) begin
      errors++;
      $display("FAIL sat_after_two_dec: got %b expected 0", p);
    end
    drive_resolve(32'h100, 32'd7, 32'd7, 5'b11001, 3'b000, 1'b1);
    checks++;
    if ({resolve_valid_out, branch_taken_out, mispredict_out} !== 3'b100) begin
      errors++;
      $display("FAIL non_branch: got %b expected 100",
               {resolve_valid_out, branch_taken_out, mispredict_out});
    end
    read_predict(32'h100, p);
    checks++;
    if (p !== 1'b0) begin
      errors++;
      $display("FAIL non_branch_no_train: got %b expected 0", p);
    end
  endtask

  task automatic test_back_to_back();
    logic p;
    predict_pc_in      = 32'h84;
    resolve_valid_in   = 1'b1;
    resolve_pc_in      = 32'h80;
    opcode_in          = OPCODE_BRANCH;
    funct3_in          = FUNCT3_BEQ;
    rs1_in             = 32'd7;
    rs2_in             = 32'd7;
    predicted_taken_in = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({resolve_valid_out, branch_taken_out, mispredict_out} !== 3'b111) begin
      errors++;
      $display("FAIL b2b_first: got %b expected 111",
               {resolve_valid_out, branch_taken_out, mispredict_out});
    end
    funct3_in          = FUNCT3_BNE;
    rs1_in             = 32'd1;
    rs2_in             = 32'd2;
    predicted_taken_in = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({resolve_valid_out, branch_taken_out, mispredict_out} !== 3'b110) begin
      errors++;
      $display("FAIL b2b_second: got %b expected 110",
               {resolve_valid_out, branch_taken_out, mispredict_out});
    end
    resolve_pc_in      = 32'h84;
    funct3_in          = FUNCT3_BLTU;
    rs1_in             = 32'd0;
    rs2_in             = 32'd1;
    predicted_taken_in = 1'b0;
    read_predict(32'h84, p);
    checks++;
    if (p !== 1'b0) begin
      errors++;
      $display("FAIL no_bypass: got %b expected 0", p);
    end
    @(posedge clk); #1;
    resolve_valid_in = 1'b0;
    checks++;
    if ({resolve_valid_out, branch_taken_out, mispredict_out} !== 3'b111) begin
      errors++;
      $display("FAIL b2b_third: got %b expected 111",
               {resolve_valid_out, branch_taken_out, mispredict_out});
    end
    read_predict(32'h84, p);
    checks++;
    if (p !== 1'b1) begin
      errors++;
      $display("FAIL post_update_predict: got %b expected 1", p);
    end
    read_predict(32'h80, p);
    checks++;
    if (p !== 1'b1) begin
      errors++;
      $display("FAIL b2b_train: got %b expected 1", p);
    end
  endtask

  task automatic test_reset_mid_run();
    logic p;
    int   cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (busy_out !== 1'b1 || resolve_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got busy=%b valid=%b expected busy=1 valid=0", busy_out, resolve_valid_out);
    end
    repeat (20) @(posedge clk);
    #1;
    read_predict(32'h40, p);
    checks++;
    if (p !== 1'b0) begin
      errors++;
      $display("FAIL predict_forced_busy: got %b expected 0", p);
    end
    drive_resolve(32'h40, 32'd9, 32'd9, OPCODE_BRANCH, FUNCT3_BEQ, 1'b0);
    checks++;
    if ({resolve_valid_out, branch_taken_out, mispredict_out, busy_out} !== 4'b1111) begin
      errors++;
      $display("FAIL init_resolve: got %b expected 1111",
               {resolve_valid_out, branch_taken_out, mispredict_out, busy_out});
    end
    cnt = 21;
    while (busy_out === 1'b1 && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
    checks++;
    if (cnt != 64) begin
      errors++;
      $display("FAIL reinit_length: got %0d cycles expected 64", cnt);
    end
    read_predict(32'h40, p);
    checks++;
    if (p !== 1'b0) begin
      errors++;
      $display("FAIL no_update_in_init: got %b expected 0", p);
    end
  endtask

`ifdef MSRV32_BP_PERF_CNT_EN
  task automatic test_perf_counters();
    int cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cnt = 0;
    while (busy_out === 1'b1 && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
    drive_resolve(32'h10, 32'd1, 32'd1, OPCODE_BRANCH, FUNCT3_BEQ, 1'b1);
    drive_resolve(32'h14, 32'd1, 32'd1, OPCODE_BRANCH, FUNCT3_BNE, 1'b0);
    drive_resolve(32'h18, 32'd1, 32'd2, OPCODE_BRANCH, FUNCT3_BLT, 1'b0);
    drive_resolve(32'h1C, 32'd1, 32'd1, 5'b11001, 3'b000, 1'b1);
    checks++;
    if (branch_count_out !== 32'd3 || mispredict_count_out !== 32'd1) begin
      errors++;
      $display("FAIL perf_counts: got %0d/%0d expected 3/1", branch_count_out, mispredict_count_out);
    end
  endtask
`endif

  initial begin
    rst                = 1'b1;
    predict_pc_in      = '0;
    resolve_valid_in   = 1'b0;
    resolve_pc_in      = '0;
    rs1_in             = '0;
    rs2_in             = '0;
    opcode_in          = '0;
    funct3_in          = '0;
    predicted_taken_in = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_beq_mispredict();
    test_conditions();
    test_saturate();
    test_back_to_back();
    test_reset_mid_run();
`ifdef MSRV32_BP_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
